// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request bus between an instruction-fetch
// port (IF) and a data-stage port (DM). One transaction is in flight at a time.
// The data port wins simultaneous requests. Define ARB_STARVE_GUARD_EN to add
// a fetch starvation counter: once fetch has waited MAX_WAIT cycles, it wins
// the next arbitration.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_dm
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [1:0] state;
  logic       owner;

  logic accept;       // memory takes the request this cycle
  logic read_accept;  // ...and it is a read
  logic rdata_take;   // read data returns this cycle for the current owner
  logic if_pick;
  logic dm_pick;

  // Grants mirror mem_ready for the current owner while the request is up.
  assign accept      = (state == S_REQ) && mem_ready;
  assign read_accept = accept && !mem_we;
  assign rdata_take  = ((state == S_WAIT_R) && mem_rvalid) || (read_accept && mem_rvalid);

  assign if_gnt = accept && (owner == OWN_IF);
  assign dm_gnt = accept && (owner == OWN_DM);

  // A port stalls while its request is unanswered or its read data is not yet back.
  assign stall_if = (if_req && !if_gnt)
                  || ((state == S_WAIT_R) && (owner == OWN_IF))
                  || (read_accept && (owner == OWN_IF));
  assign stall_dm = (dm_req && !dm_gnt)
                  || ((state == S_WAIT_R) && (owner == OWN_DM))
                  || (read_accept && (owner == OWN_DM));

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] starve_cnt;

  assign if_pick = if_req && (!dm_req || (starve_cnt >= CNT_LIMIT));

  // Count cycles fetch spends waiting; saturate, clear on its grant.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (if_req && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign if_pick = if_req && !dm_req;
`endif

  assign dm_pick = dm_req && !if_pick;

  // Arbitration FSM, registered memory bus and read-return registers.
  always_ff @(posedge clk or posedge srst) begin
    // NOTE: the async reset clears every register here, including the rdata
    // holding registers, so an abandoned read can never surface after reset.
    if (srst) begin
      state     <= S_IDLE;
      owner     <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (if_pick || dm_pick) begin
            owner     <= dm_pick ? OWN_DM : OWN_IF;
            mem_req   <= 1'b1;
            mem_addr  <= dm_pick ? dm_addr : if_addr;
            mem_we    <= dm_pick && dm_we;
            mem_wdata <= dm_pick ? dm_wdata : '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_we || mem_rvalid) begin
              state <= S_IDLE;
            end else begin
              state <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (rdata_take) begin
        if (owner == OWN_DM) begin
          dm_rvalid <= 1'b1;
          dm_rdata  <= mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table for fetch,
// write, contention and ignored-rvalid cases, plus hand-written sequences for
// reset during an outstanding read and (when ARB_STARVE_GUARD_EN is defined)
// fetch starvation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        srst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_dm;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .srst(srst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  typedef struct {
    // inputs
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dwe; logic [31:0] da; logic [31:0] dwd;
    logic        rdy; logic rv;  logic [31:0] rd;
    // expected outputs
    logic        e_if_gnt, e_if_rv, e_dm_gnt, e_dm_rv, e_mreq, e_mwe, e_st_if, e_st_dm;
    logic [31:0] e_maddr, e_mwdata, e_if_rdata, e_dm_rdata;
  } vec_t;

  vec_t vec [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_gnt"},    32'(if_gnt),    0);
    check({tag, ".if_rvalid"}, 32'(if_rvalid), 0);
    check({tag, ".if_rdata"},  if_rdata,       0);
    check({tag, ".dm_gnt"},    32'(dm_gnt),    0);
    check({tag, ".dm_rvalid"}, 32'(dm_rvalid), 0);
    check({tag, ".dm_rdata"},  dm_rdata,       0);
    check({tag, ".mem_req"},   32'(mem_req),   0);
    check({tag, ".mem_we"},    32'(mem_we),    0);
    check({tag, ".mem_addr"},  mem_addr,       0);
    check({tag, ".mem_wdata"}, mem_wdata,      0);
    check({tag, ".stall_if"},  32'(stall_if),  0);
    check({tag, ".stall_dm"},  32'(stall_dm),  0);
  endtask

  initial begin
    //            ir ia     dr dwe da     dwd           rdy rv rd           | ig irv dg drv mrq mwe sif sdm maddr  mwdata        if_rdata      dm_rdata
    vec[0]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0};
    vec[1]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 0, 32'h0,   32'h0,        32'h0,        32'h0};
    vec[2]  = '{1, 32'h40, 0, 0, 32'h0,  32'h0,        1, 0, 32'h0,        1, 0, 0, 0, 1, 0, 1, 0, 32'h40,  32'h0,        32'h0,        32'h0};
    vec[3]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 1, 32'h00A00093, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40,  32'h0,        32'h0,        32'h0};
    vec[4]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0, 0, 32'h40,  32'h0,        32'h00A00093, 32'h0};
    vec[5]  = '{0, 32'h0,  1, 1, 32'h100,32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 32'h40,  32'h0,        32'h00A00093, 32'h0};
    vec[6]  = '{0, 32'h0,  1, 1, 32'h100,32'hDEADBEEF, 1, 0, 32'h0,        0, 0, 1, 0, 1, 1, 0, 0, 32'h100, 32'hDEADBEEF, 32'h00A00093, 32'h0};
    vec[7]  = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h00A00093, 32'h0};
    vec[8]  = '{1, 32'h44, 1, 0, 32'h200,32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 32'h00A00093, 32'h0};
    vec[9]  = '{1, 32'h44, 1, 0, 32'h200,32'h0,        1, 1, 32'h11112222, 0, 0, 1, 0, 1, 0, 1, 1, 32'h200, 32'h0,        32'h00A00093, 32'h0};
    vec[10] = '{1, 32'h44, 0, 0, 32'h0,  32'h0,        0, 1, 32'h33333333, 0, 0, 0, 1, 0, 0, 1, 0, 32'h200, 32'h0,        32'h00A00093, 32'h11112222};
    vec[11] = '{1, 32'h44, 0, 0, 32'h0,  32'h0,        0, 1, 32'h44444444, 0, 0, 0, 0, 1, 0, 1, 0, 32'h44,  32'h0,        32'h00A00093, 32'h11112222};
    vec[12] = '{1, 32'h44, 0, 0, 32'h0,  32'h0,        1, 0, 32'h0,        1, 0, 0, 0, 1, 0, 1, 0, 32'h44,  32'h0,        32'h00A00093, 32'h11112222};
    vec[13] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 0, 32'h44,  32'h0,        32'h00A00093, 32'h11112222};
    vec[14] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 1, 32'h55556666, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44,  32'h0,        32'h00A00093, 32'h11112222};
    vec[15] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0, 0, 32'h44,  32'h0,        32'h55556666, 32'h11112222};
    vec[16] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'h44,  32'h0,        32'h55556666, 32'h11112222};

    // Reset state
    srst = 1'b1;
    drive_idle();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    srst = 1'b0;

    // Vector table: one row per clock cycle, checked mid-cycle
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if_req = vec[i].ir; if_addr = vec[i].ia;
      dm_req = vec[i].dr; dm_we = vec[i].dwe; dm_addr = vec[i].da; dm_wdata = vec[i].dwd;
      mem_ready = vec[i].rdy; mem_rvalid = vec[i].rv; mem_rdata = vec[i].rd;
      #1;
      check($sformatf("v%0d.if_gnt", i),    32'(if_gnt),    32'(vec[i].e_if_gnt));
      check($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(vec[i].e_if_rv));
      check($sformatf("v%0d.dm_gnt", i),    32'(dm_gnt),    32'(vec[i].e_dm_gnt));
      check($sformatf("v%0d.dm_rvalid", i), 32'(dm_rvalid), 32'(vec[i].e_dm_rv));
      check($sformatf("v%0d.mem_req", i),   32'(mem_req),   32'(vec[i].e_mreq));
      check($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(vec[i].e_mwe));
      check($sformatf("v%0d.stall_if", i),  32'(stall_if),  32'(vec[i].e_st_if));
      check($sformatf("v%0d.stall_dm", i),  32'(stall_dm),  32'(vec[i].e_st_dm));
      check($sformatf("v%0d.mem_addr", i),  mem_addr,       vec[i].e_maddr);
      check($sformatf("v%0d.mem_wdata", i), mem_wdata,      vec[i].e_mwdata);
      check($sformatf("v%0d.if_rdata", i),  if_rdata,       vec[i].e_if_rdata);
      check($sformatf("v%0d.dm_rdata", i),  dm_rdata,       vec[i].e_dm_rdata);
    end

    // Reset during an outstanding DM read; the late rvalid must be ignored
    @(negedge clk);
    drive_idle();
    dm_req = 1; dm_addr = 32'h300;
    @(negedge clk);
    mem_ready = 1;
    #1;
    check("rst_seq.dm_gnt", 32'(dm_gnt), 1);
    @(negedge clk);
    dm_req = 0; mem_ready = 0;
    #1;
    check("rst_seq.wait_stall_dm", 32'(stall_dm), 1);
    #1;
    srst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    srst = 1'b0;
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    #1;
    check_all_zero("rst_late_rvalid");
    if_req = 1; if_addr = 32'h60;
    @(negedge clk);
    mem_ready = 1;
    #1;
    check("rst_idle.mem_req",  32'(mem_req), 1);
    check("rst_idle.mem_addr", mem_addr,     32'h60);
    check("rst_idle.if_gnt",   32'(if_gnt),  1);
    @(negedge clk);
    if_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    check("rst_idle.if_rvalid", 32'(if_rvalid), 1);
    check("rst_idle.if_rdata",  if_rdata,       32'h0BADF00D);

`ifdef ARB_STARVE_GUARD_EN
    // Starvation: both ports request continuously; DM writes get two grants,
    // then the fetch counter has reached MAX_WAIT and IF wins.
    begin
      int dm_grants = 0;
      int cnt_at_grant = -1;
      bit got_if = 0;
      @(negedge clk);
      srst = 1'b1;
      drive_idle();
      @(negedge clk);
      srst = 1'b0;
      if_req = 1; if_addr = 32'h80;
      dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'h12345678;
      mem_ready = 1;
      for (int c = 0; c < 40 && !got_if; c++) begin
        #1;
        if (dm_gnt) dm_grants++;
        if (if_gnt) begin
          got_if = 1;
          cnt_at_grant = int'(dut.starve_cnt);
        end
        @(negedge clk);
      end
      check("starve.if_granted", 32'(got_if), 1);
      check("starve.dm_grants_first", 32'(dm_grants), 2);
      check("starve.cnt_reached_limit", 32'(cnt_at_grant >= 4), 1);
      #1;
      check("starve.cnt_cleared", 32'(dut.starve_cnt), 0);
      drive_idle();
    end
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 4, fetch starvation threshold in cycles; used only with the macro in REQ-025.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 srst  in  1  reset, asynchronous and active-high.
REQ-006 if_req in 1 fetch read request; if_addr in AW fetch address.
REQ-007 if_gnt out 1 fetch accepted; if_rvalid out 1 fetch data valid; if_rdata out DW fetch data.
REQ-008 dm_req in 1, dm_we in 1, dm_addr in AW, dm_wdata in DW: data-stage request, write enable, address and write data.
REQ-009 dm_gnt out 1, dm_rvalid out 1, dm_rdata out DW: data-stage accept, read valid and read data.
REQ-010 mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW: shared memory request bus.
REQ-011 mem_ready in 1 (memory accepts request), mem_rvalid in 1 (read data valid), mem_rdata in DW.
REQ-012 stall_if out 1, stall_dm out 1: stall requests to the hazard unit.

Function
REQ-013 FSM states: IDLE, REQ (mem_req held), WAIT_R (read outstanding); owner register = IF or DM.
REQ-014 Requester holds req/addr/we/wdata stable until gnt; transfer occurs when x_req and x_gnt are both high.
REQ-015 IDLE: if any req is high, latch owner, address, we (0 for IF) and wdata, and enter REQ next cycle; mem_req, mem_we, mem_addr and mem_wdata are registered.
REQ-016 Priority when both requests are high in IDLE: DM wins, unless REQ-025 overrides.
REQ-017 REQ: mem_req=1; x_gnt equals mem_ready combinationally for the owner only; non-owner gnt stays 0.
REQ-018 REQ with mem_ready=1: a write goes to IDLE; a read goes to IDLE if mem_rvalid=1 in the same cycle, otherwise to WAIT_R.
REQ-019 WAIT_R: on mem_rvalid=1, go to IDLE.
REQ-020 Read return: x_rvalid pulses for one cycle, the cycle after mem_rvalid is sampled for the owner; x_rdata is registered and held until the next read for that port completes.
REQ-021 mem_rvalid in IDLE, or in REQ before mem_ready, is ignored.
REQ-022 stall_x = (x_req & ~x_gnt) | (state==WAIT_R & owner==x) | (REQ read completing this cycle for x), combinational.
REQ-023 Latency with zero-wait memory: req sampled at cycle 0, mem_req and gnt at cycle 1, rvalid at cycle 2; one transfer every 2 cycles at most.

Reset
REQ-024 srst forces, immediately and asynchronously: state IDLE, owner IF, all outputs 0, rdata registers 0, starvation counter 0; an outstanding read is abandoned and its late mem_rvalid is ignored.

Configuration
REQ-025 Macro ARB_STARVE_GUARD_EN. When defined, a saturating counter increments each cycle that if_req=1 and if_gnt=0, and clears on if_gnt. When the counter is >= MAX_WAIT, IF wins the next IDLE arbitration. When undefined, the counter is absent and DM always wins.

Verification
REQ-026 Single fetch: if_req=1, if_addr=0x40, mem_ready=1 at cycle 1, mem_rvalid=1 with mem_rdata=0x00A00093 at cycle 2 -> mem_addr=0x40 at cycle 1, if_gnt at cycle 1, if_rvalid with if_rdata=0x00A00093 at cycle 3.
REQ-027 DM write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, mem_ready=1 -> mem_we=1 with that address and data, dm_gnt at cycle 1, no dm_rvalid, stall_dm low from cycle 2.
REQ-028 Simultaneous if_req and dm_req (read 0x200), macro undefined -> DM served first; IF held with stall_if=1 until its own grant.
REQ-029 ARB_STARVE_GUARD_EN, MAX_WAIT=4, dm_req held continuously -> IF is granted after its counter reaches 4; counter returns to 0 on that grant.
REQ-030 srst asserted in WAIT_R, then mem_rvalid=1 after release -> no rvalid, all outputs 0, FSM in IDLE.
